// File: rtl/agnus_dram_cycle_gen.sv
// Agnus-style DRAM cycle generator: turns a REQ/ACK transaction into a
// sequenced RAS/CAS cycle on nRAS0/nRAS1, nCASL/nCASU, nAWE and DRA.
// A refresh is issued as both nRAS lines low with both nCAS lines high.
// Every timing parameter must be in 1..15 because the phase counter is 4 bits.
module agnus_dram_cycle_gen #(
  parameter int unsigned T_ASR = 1,
  parameter int unsigned T_RAH = 2,
  parameter int unsigned T_CAS = 6,
  parameter int unsigned T_RP  = 5,
  parameter int unsigned T_REF = 6
) (
  input  logic        CLK80,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [20:1] A,
  input  logic        RnW,
  input  logic [1:0]  BE,
  input  logic        REF_REQ,
  output logic        ACK,
  output logic        REF_ACK,
  output logic        DONE,
  output logic        BUSY,
  output logic        nRAS0,
  output logic        nRAS1,
  output logic        nCASL,
  output logic        nCASU,
  output logic        nAWE,
  output logic [9:0]  DRA
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_RAS, S_COL, S_CAS, S_PRE, S_REFRESH
  } state_t;

  localparam logic [3:0] C_ASR = 4'(T_ASR);
  localparam logic [3:0] C_RAH = 4'(T_RAH);
  localparam logic [3:0] C_CAS = 4'(T_CAS);
  localparam logic [3:0] C_RP  = 4'(T_RP);
  localparam logic [3:0] C_REF = 4'(T_REF);

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic        accept_req, accept_ref;

  logic [20:1] lat_a;
  logic        lat_rnw;
  logic [1:0]  lat_be;

  // Transaction fields as seen by the next cycle: fresh inputs on accept.
  logic [20:1] txn_a;
  logic        txn_rnw;
  logic [1:0]  txn_be;
  logic [9:0]  row_addr, col_addr;

  logic        ack_d, ref_ack_d, done_d, busy_d;
  logic        ras0_d, ras1_d, casl_d, casu_d, awe_d;
  logic [9:0]  dra_d;

  // State and phase counter register.
  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state: each state reloads the counter on entry and exits when it
  // reaches 1; refresh wins over a simultaneous request, which stays pending.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    next_state = state;
    next_cnt   = cnt - 4'd1;
    accept_req = 1'b0;
    accept_ref = 1'b0;
    unique case (state)
      S_IDLE: begin
        next_cnt = cnt;
        if (REF_REQ) begin
          next_state = S_REFRESH;
          next_cnt   = C_REF;
          accept_ref = 1'b1;
        end else if (REQ) begin
          next_state = S_ROW;
          next_cnt   = C_ASR;
          accept_req = 1'b1;
        end
      end
      S_ROW: if (cnt == 4'd1) begin
        next_state = S_RAS;
        next_cnt   = C_RAH;
      end
      S_RAS: if (cnt == 4'd1) begin
        next_state = S_COL;
        next_cnt   = 4'd1;
      end
      S_COL: begin
        next_state = S_CAS;
        next_cnt   = C_CAS;
      end
      S_CAS: if (cnt == 4'd1) begin
        next_state = S_PRE;
        next_cnt   = C_RP;
      end
      S_REFRESH: if (cnt == 4'd1) begin
        next_state = S_PRE;
        next_cnt   = C_RP;
      end
      S_PRE: if (cnt == 4'd1) begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign txn_a    = accept_req ? A   : lat_a;
  assign txn_rnw  = accept_req ? RnW : lat_rnw;
  assign txn_be   = accept_req ? BE  : lat_be;
  assign row_addr = {txn_a[19], txn_a[17:9]};
  assign col_addr = {txn_a[20], txn_a[18], txn_a[8:1]};

  // Output decode for the state being entered, so the registered strobes
  // line up exactly with the state they belong to.
  always_comb begin
    ack_d     = accept_req;
    ref_ack_d = accept_ref;
    busy_d    = (next_state != S_IDLE);
    done_d    = 1'b0;
    ras0_d    = 1'b1;
    ras1_d    = 1'b1;
    casl_d    = 1'b1;
    casu_d    = 1'b1;
    awe_d     = 1'b1;
    dra_d     = DRA;
    unique case (next_state)
      S_ROW: dra_d = row_addr;
      S_RAS: begin
        dra_d  = row_addr;
        ras0_d = txn_a[19];
        ras1_d = ~txn_a[19];
      end
      S_COL: begin
        dra_d  = col_addr;
        ras0_d = txn_a[19];
        ras1_d = ~txn_a[19];
        awe_d  = txn_rnw;
      end
      S_CAS: begin
        dra_d  = col_addr;
        ras0_d = txn_a[19];
        ras1_d = ~txn_a[19];
        awe_d  = txn_rnw;
        casu_d = ~txn_be[1];
        casl_d = ~txn_be[0];
        done_d = (next_cnt == 4'd1);
      end
      S_REFRESH: begin
        dra_d  = '0;
        ras0_d = 1'b0;
        ras1_d = 1'b0;
        done_d = (next_cnt == 4'd1);
      end
      default: ;
    endcase
  end

  // Capture address, direction and byte enables when a request is accepted.
  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      lat_a   <= '0;
      lat_rnw <= 1'b1;
      lat_be  <= '0;
    end else if (accept_req) begin
      lat_a   <= A;
      lat_rnw <= RnW;
      lat_be  <= BE;
    end
  end

  // Output registers; reset drives every strobe inactive immediately.
  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      ACK     <= 1'b0;
      REF_ACK <= 1'b0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      nRAS0   <= 1'b1;
      nRAS1   <= 1'b1;
      nCASL   <= 1'b1;
      nCASU   <= 1'b1;
      nAWE    <= 1'b1;
      DRA     <= '0;
    end else begin
      ACK     <= ack_d;
      REF_ACK <= ref_ack_d;
      DONE    <= done_d;
      BUSY    <= busy_d;
      nRAS0   <= ras0_d;
      nRAS1   <= ras1_d;
      nCASL   <= casl_d;
      nCASU   <= casu_d;
      nAWE    <= awe_d;
      DRA     <= dra_d;
    end
  end

endmodule

// File: tb/tb_agnus_dram_cycle_gen.sv
// Bench for agnus_dram_cycle_gen: a phase model pushes the expected per-cycle
// output vectors of each transaction into a queue; the sampler pops and
// compares one vector per clock on the falling edge.
module tb_agnus_dram_cycle_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, ref_req, p_req, p_ref_req;
  logic [20:1] a;
  logic        rnw;
  logic [1:0]  be;

  logic       ack, ref_ack, done, busy, nras0, nras1, ncasl, ncasu, nawe;
  logic [9:0] dra;
  logic       p_ack, p_ref_ack, p_done, p_busy, p_nras0, p_nras1, p_ncasl, p_ncasu, p_nawe;
  logic [9:0] p_dra;

  typedef struct packed {
    logic       ack, ref_ack, done, busy, nras0, nras1, ncasl, ncasu, nawe;
    logic [9:0] dra;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  agnus_dram_cycle_gen dut (
    .CLK80(clk), .RESET(rst), .REQ(req), .A(a), .RnW(rnw), .BE(be),
    .REF_REQ(ref_req), .ACK(ack), .REF_ACK(ref_ack), .DONE(done), .BUSY(busy),
    .nRAS0(nras0), .nRAS1(nras1), .nCASL(ncasl), .nCASU(ncasu), .nAWE(nawe),
    .DRA(dra)
  );

  agnus_dram_cycle_gen #(.T_ASR(2), .T_RAH(3), .T_CAS(4), .T_RP(1), .T_REF(6)) dut_p (
    .CLK80(clk), .RESET(rst), .REQ(p_req), .A(a), .RnW(rnw), .BE(be),
    .REF_REQ(p_ref_req), .ACK(p_ack), .REF_ACK(p_ref_ack), .DONE(p_done),
    .BUSY(p_busy), .nRAS0(p_nras0), .nRAS1(p_nras1), .nCASL(p_ncasl),
    .nCASU(p_ncasu), .nAWE(p_nawe), .DRA(p_dra)
  );

  always #6 clk = ~clk;

  function automatic vec_t idle_vec(input logic [9:0] d);
    vec_t v;
    v.ack = 1'b0; v.ref_ack = 1'b0; v.done = 1'b0; v.busy = 1'b0;
    v.nras0 = 1'b1; v.nras1 = 1'b1; v.ncasl = 1'b1; v.ncasu = 1'b1;
    v.nawe = 1'b1; v.dra = d;
    return v;
  endfunction

  function automatic vec_t sample(input bit sel);
    vec_t v;
    if (sel) begin
      v.ack = p_ack; v.ref_ack = p_ref_ack; v.done = p_done; v.busy = p_busy;
      v.nras0 = p_nras0; v.nras1 = p_nras1; v.ncasl = p_ncasl; v.ncasu = p_ncasu;
      v.nawe = p_nawe; v.dra = p_dra;
    end else begin
      v.ack = ack; v.ref_ack = ref_ack; v.done = done; v.busy = busy;
      v.nras0 = nras0; v.nras1 = nras1; v.ncasl = ncasl; v.ncasu = ncasu;
      v.nawe = nawe; v.dra = dra;
    end
    return v;
  endfunction

  // Expected trace of a read/write: ROW, RAS, COL, CAS, PRE, then one IDLE.
  task automatic push_txn(input int t_asr, input int t_rah, input int t_cas,
                          input int t_rp, input logic [20:1] addr,
                          input logic rd, input logic [1:0] ben);
    logic [9:0] row, col;
    vec_t v;
    row = {addr[19], addr[17:9]};
    col = {addr[20], addr[18], addr[8:1]};
    for (int i = 0; i < t_asr; i++) begin
      v = idle_vec(row); v.busy = 1'b1; v.ack = (i == 0); exp_q.push_back(v);
    end
    for (int i = 0; i < t_rah; i++) begin
      v = idle_vec(row); v.busy = 1'b1;
      if (addr[19]) v.nras1 = 1'b0; else v.nras0 = 1'b0;
      exp_q.push_back(v);
    end
    v = idle_vec(col); v.busy = 1'b1; v.nawe = rd;
    if (addr[19]) v.nras1 = 1'b0; else v.nras0 = 1'b0;
    exp_q.push_back(v);
    for (int i = 0; i < t_cas; i++) begin
      v = idle_vec(col); v.busy = 1'b1; v.nawe = rd;
      if (addr[19]) v.nras1 = 1'b0; else v.nras0 = 1'b0;
      v.ncasu = ~ben[1]; v.ncasl = ~ben[0]; v.done = (i == t_cas - 1);
      exp_q.push_back(v);
    end
    for (int i = 0; i < t_rp; i++) begin
      v = idle_vec(col); v.busy = 1'b1; exp_q.push_back(v);
    end
    exp_q.push_back(idle_vec(col));
  endtask

  // Expected trace of a refresh: REFRESH, PRE, then one IDLE.
  task automatic push_ref(input int t_ref, input int t_rp);
    vec_t v;
    for (int i = 0; i < t_ref; i++) begin
      v = idle_vec('0); v.busy = 1'b1; v.nras0 = 1'b0; v.nras1 = 1'b0;
      v.ref_ack = (i == 0); v.done = (i == t_ref - 1);
      exp_q.push_back(v);
    end
    for (int i = 0; i < t_rp; i++) begin
      v = idle_vec('0); v.busy = 1'b1; exp_q.push_back(v);
    end
    exp_q.push_back(idle_vec('0));
  endtask

  // Pop and compare up to n expected vectors, one per falling edge. Requests
  // are released on their expected acknowledge, and the transaction inputs
  // are scrambled afterwards to show they were latched.
  task automatic run_queue(input bit sel, input string name, input int n);
    vec_t e, g;
    int   k;
    k = 0;
    while (exp_q.size() > 0 && k < n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = sample(sel);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s cycle %0d got %05h expected %05h", name, k, g, e);
      end
      if (e.ack) begin
        req = 1'b0; p_req = 1'b0;
        a = a ^ 20'hFFFFF; rnw = ~rnw; be = ~be;
      end
      if (e.ref_ack) ref_req = 1'b0;
      k++;
    end
  endtask

  task automatic check_now(input bit sel, input string name, input vec_t e);
    vec_t g;
    g = sample(sel);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %05h expected %05h", name, g, e);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_now(1'b0, "reset_held", idle_vec('0));
    check_now(1'b1, "reset_held_p", idle_vec('0));
    rst = 1'b0;
    @(negedge clk);
    check_now(1'b0, "reset_released", idle_vec('0));
  endtask

  task automatic test_read();
    a = 20'h00246; rnw = 1'b1; be = 2'b11; req = 1'b1;
    push_txn(1, 2, 6, 5, a, rnw, be);
    run_queue(1'b0, "read", 1000);
  endtask

  task automatic test_write();
    @(negedge clk);
    a = 20'h4A5C3; rnw = 1'b0; be = 2'b10; req = 1'b1;
    push_txn(1, 2, 6, 5, a, rnw, be);
    run_queue(1'b0, "write_bank1", 1000);
  endtask

  task automatic test_ref_priority();
    @(negedge clk);
    a = 20'h01234; rnw = 1'b1; be = 2'b01; req = 1'b1; ref_req = 1'b1;
    push_ref(6, 5);
    push_txn(1, 2, 6, 5, a, rnw, be);
    run_queue(1'b0, "ref_then_req", 1000);
  endtask

  task automatic test_reset_mid_cycle();
    @(negedge clk);
    a = 20'h00F0F; rnw = 1'b1; be = 2'b11; req = 1'b1;
    push_txn(1, 2, 6, 5, a, rnw, be);
    run_queue(1'b0, "pre_abort", 6);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_now(1'b0, "async_abort", idle_vec('0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_now(1'b0, "post_abort_idle", idle_vec('0));
    end
    a = 20'h2C3D5; rnw = 1'b0; be = 2'b11; req = 1'b1;
    push_txn(1, 2, 6, 5, a, rnw, be);
    run_queue(1'b0, "after_reset", 1000);
  endtask

  task automatic test_params();
    @(negedge clk);
    a = 20'h80001; rnw = 1'b0; be = 2'b01; p_req = 1'b1;
    push_txn(2, 3, 4, 1, a, rnw, be);
    run_queue(1'b1, "params", 1000);
  endtask

  task automatic test_ras_only();
    @(negedge clk);
    a = 20'h7FFFF; rnw = 1'b1; be = 2'b00; req = 1'b1;
    push_txn(1, 2, 6, 5, a, rnw, be);
    run_queue(1'b0, "be00", 1000);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; ref_req = 1'b0; p_req = 1'b0; p_ref_req = 1'b0;
    a = '0; rnw = 1'b1; be = 2'b00;
    test_reset();
    test_read();
    test_write();
    test_ref_priority();
    test_reset_mid_cycle();
    test_params();
    test_ras_only();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
